// File: rtl/nios_hps_system_clkgen_pkg.sv
// -----------------------------------------------------------------------------
// nios_hps_system_clkgen_pkg
// Shared types and constants for the divided-clock generator.
//   clk_state_e         : top-level lock FSM states
//   DEFAULT_CNT_W       : default width of the divide / phase fields
//   DEFAULT_LOCK_CYCLES : default settle delay in refclk cycles
//   ch_width()          : width of the channel-select field for N channels
// -----------------------------------------------------------------------------
package nios_hps_system_clkgen_pkg;

   typedef enum logic {
      LOCKING = 1'b0,
      LOCKED  = 1'b1
   } clk_state_e;

   localparam int DEFAULT_CNT_W       = 16;
   localparam int DEFAULT_LOCK_CYCLES = 1024;

   // A single channel still needs a one-bit select so the port exists.
   function automatic int ch_width(input int num_clocks);
      return (num_clocks > 1) ? $clog2(num_clocks) : 1;
   endfunction

endpackage

// File: rtl/nios_hps_system_clkgen_chan.sv
// -----------------------------------------------------------------------------
// nios_hps_system_clkgen_chan
// One divided-clock channel: shadow divide/phase registers, the divide
// counter and the registered output clock bit.
//   refclk  : reference clock, rising edge
//   rst     : asynchronous active-high reset
//   run     : channel free-runs this cycle
//   load    : counter loads its start value this cycle (lock edge)
//   wr_en   : capture div/phase into the shadow registers
//   div     : new divide ratio
//   phase   : new start phase
//   outclk  : registered divided clock
// With neither run nor load the counter holds and outclk is forced low.
// -----------------------------------------------------------------------------
module nios_hps_system_clkgen_chan
   import nios_hps_system_clkgen_pkg::*;
#(
   parameter int               CNT_W     = DEFAULT_CNT_W,
   parameter logic [CNT_W-1:0] DIV_RST   = CNT_W'(2),
   parameter logic [CNT_W-1:0] PHASE_RST = '0
)(
   input  logic             refclk,
   input  logic             rst,
   input  logic             run,
   input  logic             load,
   input  logic             wr_en,
   input  logic [CNT_W-1:0] div,
   input  logic [CNT_W-1:0] phase,
   output logic             outclk
);

   logic [CNT_W-1:0] div_q;
   logic [CNT_W-1:0] phase_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             outclk_d;

   logic             enabled;
   logic [CNT_W-1:0] half;
   logic [CNT_W-1:0] start;
   logic [CNT_W-1:0] cnt_inc;

   // A ratio below 2 cannot produce a clock; such a channel stays parked low.
   assign enabled = (div_q >= CNT_W'(2));
   assign half    = div_q >> 1;
   assign start   = (phase_q < div_q) ? phase_q : '0;
   // >= rather than == keeps the counter inside 0..div-1 even if it was
   // left above a newly written, smaller ratio.
   assign cnt_inc = (cnt_q >= div_q - CNT_W'(1)) ? '0 : cnt_q + CNT_W'(1);

   always_comb begin
      // NOTE: every signal gets a default before any branch so no path
      // leaves it unassigned, which would otherwise infer a latch.
      cnt_d    = cnt_q;
      outclk_d = 1'b0;
      if (load) begin
         cnt_d = enabled ? start : '0;
      end else if (run) begin
         cnt_d = enabled ? cnt_inc : '0;
      end
      // outclk is registered from the counter value it will sit beside,
      // so the bit and the counter always describe the same cycle.
      if ((run || load) && enabled) begin
         outclk_d = (cnt_d < half);
      end
   end

   // NOTE: the shadow registers reset to the parameter defaults, not to zero,
   // so a reset discards any runtime configuration.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         // NOTE: non-blocking assignments in clocked blocks so every flop
         // samples pre-edge values regardless of statement order.
         div_q   <= DIV_RST;
         phase_q <= PHASE_RST;
         cnt_q   <= '0;
         outclk  <= 1'b0;
      end else begin
         if (wr_en) begin
            div_q   <= div;
            phase_q <= phase;
         end
         cnt_q  <= cnt_d;
         outclk <= outclk_d;
      end
   end

endmodule

// File: rtl/nios_hps_system_clkgen.sv
// -----------------------------------------------------------------------------
// nios_hps_system_clkgen
// Generates NUM_CLOCKS phase-aligned divided clocks from refclk. After reset
// or any accepted configuration write, all channels are held low for
// LOCK_CYCLES cycles and then restart together from their start phases.
//   refclk    : the single clock
//   rst       : asynchronous active-high reset
//   cfg_write : configuration write strobe, qualified by cfg_ready
//   cfg_chan  : target channel (writes to channels >= NUM_CLOCKS are dropped)
//   cfg_div   : new divide ratio
//   cfg_phase : new start phase
//   cfg_ready : a write will be accepted this cycle (LOCKED only)
//   outclk    : registered divided clocks
//   locked    : all channels running with the current configuration
// -----------------------------------------------------------------------------
module nios_hps_system_clkgen
   import nios_hps_system_clkgen_pkg::*;
#(
   parameter int                          NUM_CLOCKS  = 3,
   parameter int                          CNT_W       = DEFAULT_CNT_W,
   parameter int                          LOCK_CYCLES = DEFAULT_LOCK_CYCLES,
   parameter logic [NUM_CLOCKS*CNT_W-1:0] DIV_INIT    = {NUM_CLOCKS{CNT_W'(2)}},
   parameter logic [NUM_CLOCKS*CNT_W-1:0] PHASE_INIT  = '0,
   localparam int                         CH_W        = ch_width(NUM_CLOCKS)
)(
   input  logic                  refclk,
   input  logic                  rst,
   input  logic                  cfg_write,
   input  logic [CH_W-1:0]       cfg_chan,
   input  logic [CNT_W-1:0]      cfg_div,
   input  logic [CNT_W-1:0]      cfg_phase,
   output logic                  cfg_ready,
   output logic [NUM_CLOCKS-1:0] outclk,
   output logic                  locked
);

   localparam int                LOCK_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
   localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
   localparam logic [CH_W:0]     NUM_CH    = (CH_W + 1)'(NUM_CLOCKS);

   clk_state_e              state_q;
   clk_state_e              state_d;
   logic [LOCK_W-1:0]       lock_cnt_q;
   logic [LOCK_W-1:0]       lock_cnt_d;
   logic                    accept;
   logic                    run;
   logic                    load;
   logic [NUM_CLOCKS-1:0]   wr_en;

   assign cfg_ready = (state_q == LOCKED);
   assign locked    = (state_q == LOCKED);
   assign accept    = cfg_write && cfg_ready && ({1'b0, cfg_chan} < NUM_CH);

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state_q    <= LOCKING;
         lock_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         lock_cnt_q <= lock_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      lock_cnt_d = lock_cnt_q;
      run        = 1'b0;
      load       = 1'b0;
      unique case (state_q)
         LOCKING: begin
            if (lock_cnt_q == LOCK_LAST) begin
               state_d    = LOCKED;
               lock_cnt_d = '0;
               load       = 1'b1;
            end else begin
               lock_cnt_d = lock_cnt_q + LOCK_W'(1);
            end
         end
         LOCKED: begin
            // An accepted write parks every channel, not just the target,
            // so the whole set restarts aligned after the relock.
            if (accept) begin
               state_d    = LOCKING;
               lock_cnt_d = '0;
            end else begin
               run = 1'b1;
            end
         end
         default: begin
            state_d    = LOCKING;
            lock_cnt_d = '0;
         end
      endcase
   end

   for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_chan
      assign wr_en[i] = accept && (cfg_chan == CH_W'(i));

      nios_hps_system_clkgen_chan #(
         .CNT_W     (CNT_W),
         .DIV_RST   (DIV_INIT[i*CNT_W +: CNT_W]),
         .PHASE_RST (PHASE_INIT[i*CNT_W +: CNT_W])
      ) u_chan (
         .refclk (refclk),
         .rst    (rst),
         .run    (run),
         .load   (load),
         .wr_en  (wr_en[i]),
         .div    (cfg_div),
         .phase  (cfg_phase),
         .outclk (outclk[i])
      );
   end

endmodule

// File: tb/tb_nios_hps_system_clkgen.sv
// -----------------------------------------------------------------------------
// tb_nios_hps_system_clkgen
// Self-checking bench: three channels, LOCK_CYCLES = 8, default divide 2.
// A cycle-level model tracks lock state and time since the last lock edge;
// expected outclk bits follow from (start + t) mod div < div/2. Directed
// sequences add hand-computed literal expectations on top.
// -----------------------------------------------------------------------------
module tb_nios_hps_system_clkgen;

   localparam int NCLK  = 3;
   localparam int CW    = 16;
   localparam int LOCKC = 8;

   logic            refclk = 1'b0;
   logic            rst    = 1'b0;
   logic            cfg_write = 1'b0;
   logic [1:0]      cfg_chan  = '0;
   logic [CW-1:0]   cfg_div   = '0;
   logic [CW-1:0]   cfg_phase = '0;
   logic            cfg_ready;
   logic [NCLK-1:0] outclk;
   logic            locked;

   int n_cmp  = 0;
   int n_fail = 0;
   bit cmp_on = 1'b0;

   nios_hps_system_clkgen #(
      .NUM_CLOCKS  (NCLK),
      .CNT_W       (CW),
      .LOCK_CYCLES (LOCKC)
   ) dut (
      .refclk    (refclk),
      .rst       (rst),
      .cfg_write (cfg_write),
      .cfg_chan  (cfg_chan),
      .cfg_div   (cfg_div),
      .cfg_phase (cfg_phase),
      .cfg_ready (cfg_ready),
      .outclk    (outclk),
      .locked    (locked)
   );

   always #5 refclk = ~refclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit m_locked;
   int m_wait;      // lock cycles already spent
   int m_t;         // edges since the lock edge
   int m_div   [NCLK];
   int m_phase [NCLK];

   always @(posedge refclk or posedge rst) begin
      if (rst) begin
         m_locked <= 1'b0;
         m_wait   <= 0;
         m_t      <= 0;
         for (int i = 0; i < NCLK; i++) begin
            m_div[i]   <= 2;
            m_phase[i] <= 0;
         end
      end else if (!m_locked) begin
         if (m_wait == LOCKC - 1) begin
            m_locked <= 1'b1;
            m_t      <= 0;
         end else begin
            m_wait <= m_wait + 1;
         end
      end else if (cfg_write && int'(cfg_chan) < NCLK) begin
         m_div[int'(cfg_chan)]   <= int'(cfg_div);
         m_phase[int'(cfg_chan)] <= int'(cfg_phase);
         m_locked <= 1'b0;
         m_wait   <= 0;
      end else begin
         m_t <= m_t + 1;
      end
   end

   function automatic logic [NCLK-1:0] exp_out();
      logic [NCLK-1:0] v = '0;
      for (int i = 0; i < NCLK; i++) begin
         int st = (m_phase[i] < m_div[i]) ? m_phase[i] : 0;
         if (m_locked && m_div[i] >= 2)
            v[i] = (((st + m_t) % m_div[i]) < (m_div[i] / 2));
      end
      return v;
   endfunction

   always @(negedge refclk) begin
      if (cmp_on) begin
         check("model_locked", 32'(locked), 32'(m_locked));
         check("model_cfg_ready", 32'(cfg_ready), 32'(m_locked));
         check("model_outclk", 32'(outclk), 32'(exp_out()));
      end
   end

   // ---------------- directed helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge refclk);
   endtask

   task automatic cfg_wr(input logic [1:0] ch, input int dv, input int ph);
      cfg_write = 1'b1;
      cfg_chan  = ch;
      cfg_div   = CW'(dv);
      cfg_phase = CW'(ph);
      @(negedge refclk);
      cfg_write = 1'b0;
   endtask

   // Counts negedge samples with locked low; bounded so a stuck DUT still ends.
   task automatic wait_lock(input string name, input int exp_n);
      int n = 0;
      while (locked !== 1'b1 && n < 40) begin
         n++;
         @(negedge refclk);
      end
      check(name, n, exp_n);
   endtask

   // Captures n cycles of all outclk bits, oldest sample in the MSB.
   task automatic cap(input int n, output logic [15:0] c0, output logic [15:0] c1,
                      output logic [15:0] c2);
      c0 = '0; c1 = '0; c2 = '0;
      for (int k = 0; k < n; k++) begin
         c0 = {c0[14:0], outclk[0]};
         c1 = {c1[14:0], outclk[1]};
         c2 = {c2[14:0], outclk[2]};
         @(negedge refclk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] c0, c1, c2;

      // Reset and default lock timing.
      #1 rst = 1'b1;
      cmp_on = 1'b1;
      tick(3);
      check("rst_locked", 32'(locked), 32'd0);
      check("rst_outclk", 32'(outclk), 32'd0);
      check("rst_ready", 32'(cfg_ready), 32'd0);
      rst = 1'b0;
      wait_lock("lock_after_rst", 8);
      check("first_outclk", 32'(outclk), 32'h7);
      tick(1);
      check("second_outclk", 32'(outclk), 32'h0);
      tick(1);
      check("third_outclk", 32'(outclk), 32'h7);

      // Runtime write: chan 1 div 5.
      cfg_wr(2'd1, 5, 0);
      check("wr_unlock", 32'(locked), 32'd0);
      check("wr_outclk_low", 32'(outclk), 32'd0);
      wait_lock("relock_div5", 8);
      cap(10, c0, c1, c2);
      check("div5_pattern", 32'(c1), 32'h318);
      check("div2_ch0_after_wr", 32'(c0), 32'h2AA);
      check("div2_ch2_after_wr", 32'(c2), 32'h2AA);

      // Phase: chan 2 div 4, phase 2 then phase 7 (out of range -> 0).
      cfg_wr(2'd2, 4, 2);
      wait_lock("relock_ph2", 8);
      cap(8, c0, c1, c2);
      check("div4_ph2_pattern", 32'(c2), 32'h33);
      cfg_wr(2'd2, 4, 7);
      wait_lock("relock_ph7", 8);
      cap(8, c0, c1, c2);
      check("div4_ph7_pattern", 32'(c2), 32'hCC);

      // Illegal channel: no relock.
      cfg_wr(2'd3, 9, 0);
      check("illegal_chan_locked", 32'(locked), 32'd1);
      tick(2);
      check("illegal_chan_still_locked", 32'(locked), 32'd1);

      // Disable chan 0, then a write during LOCKING that must be dropped.
      cfg_wr(2'd0, 1, 0);
      cfg_wr(2'd1, 7, 0);
      wait_lock("relock_disable", 7);
      cap(10, c0, c1, c2);
      check("disabled_ch0", 32'(c0), 32'h0);
      check("ignored_wr_ch1", 32'(c1), 32'h318);
      check("ch2_div4_ph0", 32'(c2), 32'h333);

      // Reset three cycles into LOCKED after a div-5 write.
      cfg_wr(2'd1, 5, 0);
      wait_lock("relock_before_rst", 8);
      tick(3);
      @(posedge refclk);
      #2 rst = 1'b1;
      #1;
      check("midrst_locked", 32'(locked), 32'd0);
      check("midrst_outclk", 32'(outclk), 32'd0);
      check("midrst_ready", 32'(cfg_ready), 32'd0);
      @(negedge refclk);
      tick(2);
      rst = 1'b0;
      wait_lock("lock_after_midrst", 8);
      cap(10, c0, c1, c2);
      check("ch0_default_restored", 32'(c0), 32'h2AA);
      check("ch1_default_restored", 32'(c1), 32'h2AA);
      check("ch2_default_restored", 32'(c2), 32'h2AA);

      cmp_on = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
